// File: rtl/fpu_result_collector.sv
// Result collector behind the FP32 FPU: FIFO buffer, sticky fflags, result counter and done flag.
// Optional COLLECTOR_NAN_CANON_EN: NaN results are stored as canonical qNaN 32'h7FC00000.
module fpu_result_collector #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] result_i,
    input  logic [4:0]       status_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [4:0]       out_status_o,
    output logic [4:0]       flags_o,
    input  logic             flags_clr_i,
    output logic [CNT_W-1:0] count_o,
    input  logic [CNT_W-1:0] expected_i,
    output logic             done_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = AW + 1;
    localparam logic [OW-1:0]    FULL_OCC = OW'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [WIDTH-1:0] mem_data_r   [DEPTH];
    logic [4:0]       mem_status_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [OW-1:0]    occ_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic [4:0]       out_status_r;
    logic [4:0]       flags_r;
    logic [CNT_W-1:0] count_r;
    logic             done_r;

    logic             push_s;
    logic             pop_s;
    logic [WIDTH-1:0] store_data_s;
    logic [OW-1:0]    occ_next_s;
    logic [OW-1:0]    occ_after_pop_s;
    logic [AW-1:0]    wr_ptr_next_s;
    logic [AW-1:0]    rd_ptr_next_s;
    logic [WIDTH-1:0] head_data_s;
    logic [4:0]       head_status_s;
    logic [4:0]       flags_next_s;
    logic [CNT_W-1:0] count_next_s;
    logic             done_next_s;

    function automatic logic [WIDTH-1:0] store_value(input logic [WIDTH-1:0] d);
`ifdef COLLECTOR_NAN_CANON_EN
        if ((d[30:23] == 8'hFF) && (d[22:0] != 23'd0)) begin
            return WIDTH'(32'h7FC0_0000);
        end else begin
            return d;
        end
`else
        return d;
`endif
    endfunction

    assign push_s       = in_valid_i && in_ready_r;
    assign pop_s        = out_valid_r && out_ready_i;
    assign store_data_s = store_value(result_i);

    // Next-state for pointers, occupancy and the registered head entry.
    always_comb begin
        occ_after_pop_s = occ_r;
        occ_next_s      = occ_r;
        wr_ptr_next_s   = wr_ptr_r;
        rd_ptr_next_s   = rd_ptr_r;
        head_data_s     = out_data_r;
        head_status_s   = out_status_r;

        if (pop_s) begin
            occ_after_pop_s = occ_r - OW'(1);
            rd_ptr_next_s   = rd_ptr_r + AW'(1);
        end else begin
            occ_after_pop_s = occ_r;
            rd_ptr_next_s   = rd_ptr_r;
        end

        if (push_s) begin
            occ_next_s    = occ_after_pop_s + OW'(1);
            wr_ptr_next_s = wr_ptr_r + AW'(1);
        end else begin
            occ_next_s    = occ_after_pop_s;
            wr_ptr_next_s = wr_ptr_r;
        end

        // Head comes from the incoming word only when it lands in an otherwise empty FIFO.
        if (occ_next_s == OW'(0)) begin
            head_data_s   = out_data_r;
            head_status_s = out_status_r;
        end else if (occ_after_pop_s == OW'(0)) begin
            head_data_s   = store_data_s;
            head_status_s = status_i;
        end else begin
            head_data_s   = mem_data_r[rd_ptr_next_s];
            head_status_s = mem_status_r[rd_ptr_next_s];
        end
    end

    // Next-state for sticky flags, saturating counter and done.
    always_comb begin
        flags_next_s = flags_r;
        count_next_s = count_r;
        done_next_s  = done_r;

        if (flags_clr_i) begin
            flags_next_s = push_s ? status_i : 5'b00000;
        end else if (push_s) begin
            flags_next_s = flags_r | status_i;
        end else begin
            flags_next_s = flags_r;
        end

        if (push_s && (count_r != CNT_MAX)) begin
            count_next_s = count_r + CNT_W'(1);
        end else begin
            count_next_s = count_r;
        end

        // No push implies the post-update count equals the current count.
        if ((expected_i != CNT_W'(0)) && (occ_r == OW'(0)) && !push_s && !pop_s &&
            (count_r == expected_i)) begin
            done_next_s = 1'b1;
        end else begin
            done_next_s = done_r;
        end
    end

    // Control, head and bookkeeping registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            occ_r        <= '0;
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
            out_data_r   <= '0;
            out_status_r <= 5'b00000;
            flags_r      <= 5'b00000;
            count_r      <= '0;
            done_r       <= 1'b0;
        end else begin
            wr_ptr_r     <= wr_ptr_next_s;
            rd_ptr_r     <= rd_ptr_next_s;
            occ_r        <= occ_next_s;
            in_ready_r   <= (occ_next_s != FULL_OCC);
            out_valid_r  <= (occ_next_s != OW'(0));
            out_data_r   <= head_data_s;
            out_status_r <= head_status_s;
            flags_r      <= flags_next_s;
            count_r      <= count_next_s;
            done_r       <= done_next_s;
        end
    end

    // Storage array; contents are don't-care until written, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_data_r[wr_ptr_r]   <= store_data_s;
            mem_status_r[wr_ptr_r] <= status_i;
        end else begin
            mem_data_r[wr_ptr_r]   <= mem_data_r[wr_ptr_r];
            mem_status_r[wr_ptr_r] <= mem_status_r[wr_ptr_r];
        end
    end

    assign in_ready_o   = in_ready_r;
    assign out_valid_o  = out_valid_r;
    assign out_data_o   = out_data_r;
    assign out_status_o = out_status_r;
    assign flags_o      = flags_r;
    assign count_o      = count_r;
    assign done_o       = done_r;

endmodule
